// File: rtl/data_read_pkg.sv
// Shared constants, types and decode helpers for the capture-core AXI read path.
package data_read_pkg;

  localparam logic [8:0] ADDR_STATUS   = 9'h000;
  localparam logic [8:0] ADDR_VERSION  = 9'h004;
  localparam logic [8:0] ADDR_BUF_BASE = 9'h100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Samples gathered per 32-bit AXI word.
  localparam int SAMPLES_PER_WORD = 8;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} rd_state_e;

  // Response as held on the R channel.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_rsp_t;

  function automatic logic is_buf_addr(input logic [8:0] a);
    return a[8];
  endfunction

endpackage

// File: rtl/data_read_axi_rd_ctrl_if.sv
// AXI4-Lite read-channel bundle (AR + R) between the bus master and the capture read slave.
interface data_read_axi_rd_ctrl_if #(parameter int C_S_AXI_ADDR_WIDTH = 32);
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;
  logic [31:0]                   S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/data_read_sync2.sv
// Two-flop synchroniser for a slow level, plus a registered pulse on its falling edge.
module data_read_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      q    <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      q    <= s1;
      fall <= q & ~s1;
    end
  end
endmodule

// File: rtl/data_read_axi_rd_ctrl.sv
// AXI4-Lite read slave: STATUS/VERSION registers and packed 8x4-bit capture buffer reads.
// Optional DATA_READ_BUSY_GUARD_EN: BUF reads while capture is busy return SLVERR without fetching.
module data_read_axi_rd_ctrl
  import data_read_pkg::*;
#(
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_BUF_AW           = 9,
  parameter int          C_SAMPLE_W         = 4,
  parameter logic [31:0] C_VERSION          = 32'h0001_0000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  data_read_axi_rd_ctrl_if.slave axi,
  output logic [C_BUF_AW-1:0]   buf_rd_addr,
  input  logic [C_SAMPLE_W-1:0] buf_rd_data,
  input  logic                  cap_busy_async
);
  rd_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [C_BUF_AW-4:0]   word_q, word_d;
  logic                  is_status_q, is_status_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  rd_rsp_t               rsp_q, rsp_d;
  logic [C_BUF_AW-1:0]   addr_q, addr_d;
  logic                  done_q;
  logic                  busy_sync, busy_fall, guard_block, r_hs;
  logic [8:0]            ar9, off;
  logic [2:0]            nib;

  data_read_sync2 u_sync (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .d     (cap_busy_async),
    .q     (busy_sync),
    .fall  (busy_fall)
  );

`ifdef DATA_READ_BUSY_GUARD_EN
  assign guard_block = busy_sync;
`else
  assign guard_block = 1'b0;
`endif

  assign ar9 = axi.S_AXI_ARADDR[8:0];
  assign off = {ar9[8:2], 2'b00};
  assign nib = cnt_q[2:0] - 3'd1;

  logic unused_araddr;
  assign unused_araddr = ^{axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:9], axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    is_status_d = is_status_q;
    rvalid_d    = rvalid_q;
    rsp_d       = rsp_q;
    addr_d      = addr_q;
    r_hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (axi.S_AXI_ARVALID && arready_q) begin
          word_d      = ar9[7:2];
          is_status_d = (off == ADDR_STATUS);
          cnt_d       = '0;
          rsp_d       = '{data: '0, resp: RESP_OKAY};
          if (is_buf_addr(ar9) && !guard_block) begin
            state_d = FETCH;
            addr_d  = {ar9[7:2], 3'd0};
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            if (off == ADDR_STATUS) begin
              rsp_d.data[STATUS_BUSY_BIT] = busy_sync;
              rsp_d.data[STATUS_DONE_BIT] = done_q;
            end else if (off == ADDR_VERSION) begin
              rsp_d.data = C_VERSION;
            end else begin
              rsp_d.resp = RESP_SLVERR;
            end
          end
        end
      end
      FETCH: begin
        // cnt_q = j-1 on fetch edge j: address sample j, capture sample j-2.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q < 4'd7) addr_d = {word_q, cnt_q[2:0] + 3'd1};
        if (cnt_q >= 4'd1) rsp_d.data[{nib, 2'b00} +: 4] = buf_rd_data;
        if (cnt_q == 4'd8) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
        end
      end
      RESP: begin
        if (axi.S_AXI_RREADY) begin
          r_hs     = 1'b1;
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      is_status_q <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rsp_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      is_status_q <= is_status_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rsp_q       <= rsp_d;
      addr_q      <= addr_d;
    end
  end

  // A fall landing on the clearing STATUS handshake must not be lost.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)               done_q <= 1'b0;
    else if (busy_fall)               done_q <= 1'b1;
    else if (r_hs && is_status_q)     done_q <= 1'b0;
  end

  assign axi.S_AXI_ARREADY = arready_q;
  assign axi.S_AXI_RVALID  = rvalid_q;
  assign axi.S_AXI_RDATA   = rsp_q.data;
  assign axi.S_AXI_RRESP   = rsp_q.resp;
  assign buf_rd_addr       = addr_q;

endmodule

// File: tb/tb_data_read_axi_rd_ctrl.sv
// Randomized bench for data_read_axi_rd_ctrl against an event-history reference model.
module tb_data_read_axi_rd_ctrl;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cap_busy = 1'b0;
  logic [8:0] buf_rd_addr;
  logic [3:0] buf_rd_data;
  logic [3:0] mem [512];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit hist   [MAXC];
  bit rstlow [MAXC];
  bit clrev  [MAXC];

  data_read_axi_rd_ctrl_if axi ();

  data_read_axi_rd_ctrl dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .axi            (axi),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_data    (buf_rd_data),
    .cap_busy_async (cap_busy)
  );

  always #5 clk = ~clk;

  // Registered RAM read port.
  always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

  // Per-edge history: busy level seen and whether reset was held.
  always @(posedge clk) begin
    cyc             <= cyc + 1;
    rstlow[cyc + 1] <= !rst_n;
    hist[cyc + 1]   <= rst_n && cap_busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // busy_sync seen just before edge a is the level sampled two edges earlier.
  function automatic bit busy_before(input int a);
    if (a < 3 || rstlow[a-1] || rstlow[a-2]) return 1'b0;
    return hist[a-2];
  endfunction

  // done is set on the edge after the synchronised level's first low cycle.
  function automatic bit set_at(input int e);
    if (e < 4) return 1'b0;
    for (int k = e - 3; k <= e; k++) if (rstlow[k]) return 1'b0;
    return hist[e-3] && !hist[e-2];
  endfunction

  function automatic bit done_before(input int a);
    for (int e = a - 1; e >= 1; e--) begin
      if (rstlow[e]) return 1'b0;
      if (set_at(e)) return 1'b1;
      if (clrev[e])  return 1'b0;
    end
    return 1'b0;
  endfunction

  task automatic model(input logic [8:0] a9, input int a, output logic [31:0] d,
                       output logic [1:0] r, output int lat, output bit fetch);
    logic [8:0] offs;
    offs  = a9 & 9'h1FC;
    d     = '0;
    r     = 2'b00;
    lat   = 1;
    fetch = 1'b0;
    if (offs == 9'h000) begin
      d[0] = busy_before(a);
      d[1] = done_before(a);
    end else if (offs == 9'h004) begin
      d = 32'h0001_0000;
    end else if (a9 >= 9'h100) begin
`ifdef DATA_READ_BUSY_GUARD_EN
      if (busy_before(a)) r = 2'b10;
      else fetch = 1'b1;
`else
      fetch = 1'b1;
`endif
      if (fetch) begin
        lat = 10;
        for (int k = 0; k < 8; k++) d[4*k +: 4] = mem[{a9[7:2], 3'(k)}];
      end
    end else begin
      r = 2'b10;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdly, output logic [31:0] got);
    int         a, lat, elat, n, h;
    logic [31:0] ed;
    logic [1:0]  er;
    bit          fetch;
    logic [8:0]  a9;
    a9 = addr[8:0];
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!axi.S_AXI_ARREADY && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ar_wait", 32'(axi.S_AXI_ARREADY), 32'd1);
    @(posedge clk); #1;
    a = cyc;
    axi.S_AXI_ARVALID = 1'b0;
    model(a9, a, ed, er, elat, fetch);
    lat = 1;
    while (!axi.S_AXI_RVALID && lat < 30) begin
      chk("ar_busy", 32'(axi.S_AXI_ARREADY), 32'd0);
      if (fetch && lat <= 8) chk("buf_addr", 32'(buf_rd_addr), 32'({a9[7:2], 3'(lat - 1)}));
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("rdata", axi.S_AXI_RDATA, ed);
    chk("rresp", 32'(axi.S_AXI_RRESP), 32'(er));
    got = axi.S_AXI_RDATA;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      chk("hold_rvalid", 32'(axi.S_AXI_RVALID), 32'd1);
      chk("hold_rdata", axi.S_AXI_RDATA, ed);
      chk("hold_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    end
    axi.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    h = cyc;
    axi.S_AXI_RREADY = 1'b0;
    if ((a9 & 9'h1FC) == 9'h000) clrev[h] = 1'b1;
    chk("post_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    chk("post_arready", 32'(axi.S_AXI_ARREADY), 32'd1);
  endtask

  initial begin
    logic [31:0] d, addr;
    logic [8:0]  a9;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 4'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    chk("rst_rdata", axi.S_AXI_RDATA, 32'd0);
    chk("rst_rresp", 32'(axi.S_AXI_RRESP), 32'd0);
    chk("rst_bufaddr", 32'(buf_rd_addr), 32'd0);
    rst_n = 1'b1;

    do_read(32'h004, 0, d);
    chk("version", d, 32'h0001_0000);

    for (int i = 0; i < 8; i++) mem[8 + i] = 4'(i + 1);
    do_read(32'h104, 0, d);
    chk("buf_word1", d, 32'h8765_4321);

    cap_busy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    cap_busy = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    do_read(32'h000, 0, d);
    chk("status_done", d, 32'h2);
    do_read(32'h000, 0, d);
    chk("status_clr", d, 32'h0);

    // Sweep the busy fall across the STATUS R handshake, including the coincident edge.
    for (int o = 0; o < 6; o++) begin
      cap_busy = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      fork
        do_read(32'h000, 3, d);
        begin
          repeat (o) @(posedge clk);
          #1;
          cap_busy = 1'b0;
        end
      join
      repeat (6) @(posedge clk);
      #1;
      do_read(32'h000, 0, d);
    end

    do_read(32'h050, 0, d);
    do_read(32'h1FC, 5, d);

    // Reset in the middle of a buffer fetch.
    axi.S_AXI_ARADDR  = 32'h108;
    axi.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    chk("abort_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    chk("abort_rdata", axi.S_AXI_RDATA, 32'd0);
    chk("abort_bufaddr", 32'(buf_rd_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_read(32'h004, 0, d);

    cap_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    do_read(32'h100, 0, d);
    cap_busy = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       a9 = {7'd0, 2'($urandom)};
        1:       a9 = {7'd1, 2'($urandom)};
        2:       a9 = {1'b1, 8'($urandom)};
        default: a9 = 9'($urandom);
      endcase
      addr = $urandom;
      addr[8:0] = a9;
      if ($urandom_range(0, 2) == 0) cap_busy = ~cap_busy;
      if ($urandom_range(0, 3) == 0) mem[{1'b0, 8'($urandom)}] = 4'($urandom);
      if ($urandom_range(0, 3) == 0) mem[{1'b1, 8'($urandom)}] = 4'($urandom);
      do_read(addr, $urandom_range(0, 3), d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
